// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the accumulator CPU sequencer and ALU.
//   state_e    - instruction cycle phase encoding
//   OP_*       - opcode field values (instruction[7:5])
//   SHIFT_RIGHT_OP - SHIFT operand value selecting a right shift
//   addr_sel_e - memory address source selected by the sequencer decode
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'b00,
      DECODE = 2'b01,
      EXEC_A = 2'b10,
      EXEC_B = 2'b11
   } state_e;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_NAND  = 3'b010;
   localparam logic [2:0] OP_SHIFT = 3'b011;
   localparam logic [2:0] OP_LD    = 3'b100;
   localparam logic [2:0] OP_ST    = 3'b101;
   localparam logic [2:0] OP_JC    = 3'b110;
   localparam logic [2:0] OP_JZ    = 3'b111;

   localparam logic [4:0] SHIFT_RIGHT_OP = 5'h1f;

   typedef enum logic [1:0] {
      ADDR_NONE = 2'b00,
      ADDR_PC   = 2'b01,
      ADDR_OP   = 2'b10
   } addr_sel_e;

endpackage

// File: rtl/cpu_seq_decode.sv
// cpu_seq_decode: combinational bus-access decode for the instruction sequencer.
// Ports:
//   state       in  2  current cycle phase
//   opcode      in  3  instruction[7:5]
//   run         in  1  execute enable (only meaningful in FETCH)
//   reset       in  1  active-low reset; forces all strobes off
//   mem_rd      out 1  memory read strobe
//   mem_wr      out 1  memory write strobe
//   addr_sel    out 2  address source (addr_sel_e)
//   needs_ready out 1  phase may only advance when mem_ready is high
module cpu_seq_decode
   import cpu_pkg::*;
(
   input  logic [1:0] state,
   input  logic [2:0] opcode,
   input  logic       run,
   input  logic       reset,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [1:0] addr_sel,
   output logic       needs_ready
);

   always_comb begin
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      addr_sel    = ADDR_NONE;
      needs_ready = 1'b0;
      // While reset is held nothing touches the bus, whatever the phase.
      if (reset) begin
         unique case (state_e'(state))
            FETCH: begin
               if (run) begin
                  mem_rd      = 1'b1;
                  addr_sel    = ADDR_PC;
                  needs_ready = 1'b1;
               end
            end
            DECODE: ;
            EXEC_A: begin
               if (opcode == OP_LD) begin
                  mem_rd      = 1'b1;
                  addr_sel    = ADDR_OP;
                  needs_ready = 1'b1;
               end
            end
            EXEC_B: begin
               if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_NAND) begin
                  mem_rd      = 1'b1;
                  addr_sel    = ADDR_OP;
                  needs_ready = 1'b1;
               end else if (opcode == OP_ST) begin
                  mem_wr      = 1'b1;
                  addr_sel    = ADDR_OP;
                  needs_ready = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: instruction sequencer for the 8-bit accumulator CPU. Holds the program
// counter and instruction register and steps FETCH -> DECODE -> EXEC_A -> EXEC_B.
// Ports:
//   tclk        in  1  clock, rising edge
//   reset       in  1  synchronous active-low reset
//   run         in  1  1 = execute, 0 = idle in FETCH
//   mem_ready   in  1  memory completes the current access this cycle
//   c, z        in  1  ALU carry / zero flags (conditional jumps)
//   d_bus       in  8  data bus, captured as the instruction in FETCH
//   instruction out 8  instruction register
//   state       out 2  current cycle phase
//   pc          out 5  program counter
//   addr        out 5  memory address
//   mem_rd      out 1  memory read strobe
//   mem_wr      out 1  memory write strobe
module cpu_seq
   import cpu_pkg::*;
#(
   parameter logic [4:0] PC_RESET = 5'h00
) (
   input  logic       tclk,
   input  logic       reset,
   input  logic       run,
   input  logic       mem_ready,
   input  logic       c,
   input  logic       z,
   input  logic [7:0] d_bus,
   output logic [7:0] instruction,
   output logic [1:0] state,
   output logic [4:0] pc,
   output logic [4:0] addr,
   output logic       mem_rd,
   output logic       mem_wr
);

   state_e     state_q, state_d;
   logic [4:0] pc_q, pc_d;
   logic [7:0] instr_q, instr_d;

   logic [1:0] addr_sel;
   logic       needs_ready;
   logic [2:0] opcode;
   logic [4:0] operand;

   assign opcode  = instr_q[7:5];
   assign operand = instr_q[4:0];

   cpu_seq_decode u_decode (
      .state       (state_q),
      .opcode      (opcode),
      .run         (run),
      .reset       (reset),
      .mem_rd      (mem_rd),
      .mem_wr      (mem_wr),
      .addr_sel    (addr_sel),
      .needs_ready (needs_ready)
   );

   always_comb begin
      addr = 5'h00;
      unique case (addr_sel)
         ADDR_PC: addr = pc_q;
         ADDR_OP: addr = operand;
         default: addr = 5'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         FETCH: begin
            // needs_ready is only set here when run is high.
            if (needs_ready && mem_ready) begin
               instr_d = d_bus;
               pc_d    = pc_q + 5'd1;
               state_d = DECODE;
            end
         end
         DECODE: state_d = EXEC_A;
         EXEC_A: begin
            if (!needs_ready || mem_ready) begin
               state_d = EXEC_B;
               if ((opcode == OP_JC && c) || (opcode == OP_JZ && z)) begin
                  pc_d = operand;
               end
            end
         end
         EXEC_B: begin
            if (!needs_ready || mem_ready) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge tclk) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= PC_RESET;
         instr_q <= 8'h00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign state       = state_q;
   assign pc          = pc_q;
   assign instruction = instr_q;

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: directed bench for cpu_seq. Inputs change 1 time unit after the
// rising edge; outputs are sampled before the next rising edge.
module tb_cpu_seq;

   logic       tclk;
   logic       reset;
   logic       run;
   logic       mem_ready;
   logic       c;
   logic       z;
   logic [7:0] d_bus;
   logic [7:0] instruction;
   logic [1:0] state;
   logic [4:0] pc;
   logic [4:0] addr;
   logic       mem_rd;
   logic       mem_wr;

   int total;
   int bad;

   cpu_seq #(
      .PC_RESET (5'h00)
   ) dut (
      .tclk        (tclk),
      .reset       (reset),
      .run         (run),
      .mem_ready   (mem_ready),
      .c           (c),
      .z           (z),
      .d_bus       (d_bus),
      .instruction (instruction),
      .state       (state),
      .pc          (pc),
      .addr        (addr),
      .mem_rd      (mem_rd),
      .mem_wr      (mem_wr)
   );

   initial tclk = 1'b0;
   always #5 tclk = ~tclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge tclk);
      #1;
   endtask

   // Runs one instruction from FETCH with mem_ready high throughout.
   task automatic exec_instr(input string tag, input logic [7:0] ins,
                             input logic [4:0] fetch_addr, input logic [4:0] pc_after,
                             input logic ea_rd, input logic eb_rd, input logic eb_wr);
      logic [4:0] op;
      op        = ins[4:0];
      d_bus     = ins;
      mem_ready = 1'b1;
      #1;
      check({tag, " fetch state"}, 32'(state), 32'd0);
      check({tag, " fetch rd"}, 32'(mem_rd), 32'd1);
      check({tag, " fetch wr"}, 32'(mem_wr), 32'd0);
      check({tag, " fetch addr"}, 32'(addr), 32'(fetch_addr));
      tick();
      check({tag, " decode state"}, 32'(state), 32'd1);
      check({tag, " ir"}, 32'(instruction), 32'(ins));
      check({tag, " pc+1"}, 32'(pc), 32'(5'(fetch_addr + 5'd1)));
      check({tag, " decode rd"}, 32'(mem_rd), 32'd0);
      tick();
      check({tag, " exa state"}, 32'(state), 32'd2);
      check({tag, " exa rd"}, 32'(mem_rd), 32'(ea_rd));
      check({tag, " exa wr"}, 32'(mem_wr), 32'd0);
      check({tag, " exa addr"}, 32'(addr), ea_rd ? 32'(op) : 32'd0);
      tick();
      check({tag, " exb state"}, 32'(state), 32'd3);
      check({tag, " exb rd"}, 32'(mem_rd), 32'(eb_rd));
      check({tag, " exb wr"}, 32'(mem_wr), 32'(eb_wr));
      check({tag, " exb addr"}, 32'(addr), (eb_rd || eb_wr) ? 32'(op) : 32'd0);
      tick();
      check({tag, " end state"}, 32'(state), 32'd0);
      check({tag, " end pc"}, 32'(pc), 32'(pc_after));
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b0;
      run       = 1'b0;
      mem_ready = 1'b0;
      c         = 1'b0;
      z         = 1'b0;
      d_bus     = 8'h00;

      // Reset state; strobes stay off while reset is low even with run high.
      tick();
      tick();
      run = 1'b1;
      #1;
      check("rst state", 32'(state), 32'd0);
      check("rst pc", 32'(pc), 32'd0);
      check("rst ir", 32'(instruction), 32'd0);
      check("rst rd", 32'(mem_rd), 32'd0);
      check("rst addr", 32'(addr), 32'd0);
      run = 1'b0;

      // Idle in FETCH with run low for 10 cycles; mem_ready high must be ignored.
      tick();
      reset     = 1'b1;
      mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("idle state", 32'(state), 32'd0);
         check("idle strobes", 32'({mem_rd, mem_wr}), 32'd0);
         tick();
      end
      check("idle pc", 32'(pc), 32'd0);

      // run rises: fetch at addr 0 in the same cycle; one stall cycle first.
      run       = 1'b1;
      mem_ready = 1'b0;
      #1;
      check("run rd", 32'(mem_rd), 32'd1);
      check("run addr", 32'(addr), 32'd0);
      tick();
      check("stall fetch state", 32'(state), 32'd0);
      check("stall fetch pc", 32'(pc), 32'd0);

      // LD 5 at pc 0.
      exec_instr("ld", 8'h85, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);

      // ST 3 at pc 1 with mem_ready low for two cycles in EXEC_B.
      d_bus     = 8'hA3;
      mem_ready = 1'b1;
      tick();
      check("st ir", 32'(instruction), 32'hA3);
      tick();
      check("st exa state", 32'(state), 32'd2);
      check("st exa strobes", 32'({mem_rd, mem_wr}), 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         mem_ready = (i == 2);
         #1;
         check("st exb state", 32'(state), 32'd3);
         check("st exb wr", 32'(mem_wr), 32'd1);
         check("st exb rd", 32'(mem_rd), 32'd0);
         check("st exb addr", 32'(addr), 32'd3);
         tick();
      end
      check("st end state", 32'(state), 32'd0);
      check("st end pc", 32'(pc), 32'd2);

      // Conditional jumps.
      c = 1'b0;
      z = 1'b1;
      exec_instr("jz taken", 8'hEC, 5'd2, 5'd12, 1'b0, 1'b0, 1'b0);
      z = 1'b0;
      c = 1'b1;
      exec_instr("jz not", 8'hEC, 5'd12, 5'd13, 1'b0, 1'b0, 1'b0);
      exec_instr("jc taken", 8'hCC, 5'd13, 5'd12, 1'b0, 1'b0, 1'b0);
      c = 1'b0;
      z = 1'b1;
      exec_instr("jc not", 8'hCC, 5'd12, 5'd13, 1'b0, 1'b0, 1'b0);

      // Jump to 31, then SHIFT right at pc 31 wraps pc to 0.
      exec_instr("jz 31", 8'hFF, 5'd13, 5'd31, 1'b0, 1'b0, 1'b0);
      z = 1'b0;
      exec_instr("shift wrap", 8'h7F, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);

      // ADD 4 stalled in EXEC_B, then reset abandons the access.
      d_bus     = 8'h04;
      mem_ready = 1'b1;
      tick();
      tick();
      tick();
      mem_ready = 1'b0;
      #1;
      check("add exb state", 32'(state), 32'd3);
      check("add exb rd", 32'(mem_rd), 32'd1);
      check("add exb addr", 32'(addr), 32'd4);
      tick();
      check("add stall state", 32'(state), 32'd3);
      reset = 1'b0;
      #1;
      check("add rst strobes", 32'({mem_rd, mem_wr}), 32'd0);
      check("add rst addr", 32'(addr), 32'd0);
      tick();
      check("add rst state", 32'(state), 32'd0);
      check("add rst pc", 32'(pc), 32'd0);
      check("add rst ir", 32'(instruction), 32'd0);
      check("add rst rd", 32'(mem_rd), 32'd0);
      reset = 1'b1;
      #1;
      check("post rst rd", 32'(mem_rd), 32'd1);
      check("post rst addr", 32'(addr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
